// File: rtl/cv32e40p_pm_unit.sv
// -----------------------------------------------------------------------------
// cv32e40p_pm_unit
//   Multi-domain power-management unit. It owns NUM_DOM independent clock
//   gates. Each gate is driven by its own FSM, which waits through an idle
//   hysteresis before gating and a warm-up period after wake before it reports
//   ready. The unit also keeps a saturating count of the cycles in which every
//   domain is asleep.
//
// Ports
//   clk_ungated_i   free-running clock; every register is clocked on it
//   rst_n           synchronous active-low reset
//   scan_cg_en_i    forces all clock gates open (test); the FSMs ignore it
//   fetch_enable_i  start pulse, captured sticky into fetch_enable_o
//   busy_i[d]       domain d has outstanding work
//   sleep_req_i[d]  domain d requests sleep (level)
//   wake_i[d]       domain d wake event (level)
//   clk_en_o[d]     gate enable of domain d
//   clk_gated_o[d]  gated clock of domain d
//   ready_o[d]      domain d is in RUN or IDLE
//   sleep_o[d]      domain d is in SLEEP
//   core_sleep_o    every domain is in SLEEP
//   slp_cnt_clr_i   clears the sleep-cycle counter
//   slp_cnt_o       saturating count of cycles with core_sleep_o=1
//
// Per-domain FSM
//   state | meaning
//   OFF   | after reset, clock gated, waiting for the sticky fetch enable
//   RUN   | clock running, domain active
//   IDLE  | clock running, sleep requested, hysteresis countdown in progress
//   SLEEP | clock gated (it opens combinationally while wake_i is high)
//   WAKE  | clock running, warm-up countdown in progress, not yet ready
// -----------------------------------------------------------------------------

module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_l;

  // The enable latch is transparent while the clock is low, so the gated
  // clock cannot glitch during the high phase.
  always_latch begin
    if (!clk_i) en_l = en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & en_l;

endmodule

module cv32e40p_pm_unit #(
  parameter int NUM_DOM   = 2,
  parameter int IDLE_HYST = 4,
  parameter int WAKE_LAT  = 2,
  parameter int SLP_CNT_W = 32
) (
  input  logic                 clk_ungated_i,
  input  logic                 rst_n,
  input  logic                 scan_cg_en_i,
  input  logic                 fetch_enable_i,
  output logic                 fetch_enable_o,
  input  logic [NUM_DOM-1:0]   busy_i,
  input  logic [NUM_DOM-1:0]   sleep_req_i,
  input  logic [NUM_DOM-1:0]   wake_i,
  output logic [NUM_DOM-1:0]   clk_en_o,
  output logic [NUM_DOM-1:0]   clk_gated_o,
  output logic [NUM_DOM-1:0]   ready_o,
  output logic [NUM_DOM-1:0]   sleep_o,
  output logic                 core_sleep_o,
  input  logic                 slp_cnt_clr_i,
  output logic [SLP_CNT_W-1:0] slp_cnt_o
);

  localparam int MAX_DLY = (IDLE_HYST > WAKE_LAT) ? IDLE_HYST : WAKE_LAT;
  localparam int CNT_W   = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);

  // Reload values. A zero delay never loads the counter, so clamp at 0.
  localparam logic [CNT_W-1:0] IDLE_INIT = CNT_W'((IDLE_HYST > 0) ? IDLE_HYST - 1 : 0);
  localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'((WAKE_LAT  > 0) ? WAKE_LAT  - 1 : 0);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_IDLE  = 3'd2,
    S_SLEEP = 3'd3,
    S_WAKE  = 3'd4
  } state_e;

  logic                 fetch_enable_q;
  logic [SLP_CNT_W-1:0] slp_cnt_q, slp_cnt_d;

  always_ff @(posedge clk_ungated_i) begin
    if (!rst_n) fetch_enable_q <= 1'b0;
    else        fetch_enable_q <= fetch_enable_q | fetch_enable_i;
  end

  assign fetch_enable_o = fetch_enable_q;

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_en;

    // When a wake and a sleep request arrive together, the wake wins: every
    // sleep-ward transition requires !wake_i.
    always_ff @(posedge clk_ungated_i) begin
      if (!rst_n) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            if (fetch_enable_q) state_q <= S_RUN;
          end
          S_RUN: begin
            if (sleep_req_i[d] && !busy_i[d] && !wake_i[d]) begin
              if (IDLE_HYST == 0) begin
                state_q <= S_SLEEP;
              end else begin
                state_q <= S_IDLE;
                cnt_q   <= IDLE_INIT;
              end
            end
          end
          S_IDLE: begin
            if (busy_i[d] || wake_i[d] || !sleep_req_i[d]) state_q <= S_RUN;
            else if (cnt_q == '0)                          state_q <= S_SLEEP;
            else                                           cnt_q   <= cnt_q - 1'b1;
          end
          S_SLEEP: begin
            if (wake_i[d]) begin
              if (WAKE_LAT == 0) begin
                state_q <= S_RUN;
              end else begin
                state_q <= S_WAKE;
                cnt_q   <= WAKE_INIT;
              end
            end
          end
          S_WAKE: begin
            if (cnt_q == '0) state_q <= S_RUN;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          default: state_q <= S_OFF;
        endcase
      end
    end

    // In SLEEP the enable follows wake_i directly, so the domain already
    // receives a clock edge in the cycle in which the wake arrives.
    always_comb begin
      clk_en = 1'b0;
      case (state_q)
        S_RUN, S_IDLE, S_WAKE: clk_en = 1'b1;
        S_SLEEP:               clk_en = wake_i[d];
        default:               clk_en = 1'b0;
      endcase
    end

    assign clk_en_o[d] = clk_en | scan_cg_en_i;
    assign ready_o[d]  = (state_q == S_RUN) || (state_q == S_IDLE);
    assign sleep_o[d]  = (state_q == S_SLEEP);

    cv32e40p_clock_gate u_cg (
      .clk_i        (clk_ungated_i),
      .en_i         (clk_en),
      .scan_cg_en_i (scan_cg_en_i),
      .clk_o        (clk_gated_o[d])
    );
  end

  assign core_sleep_o = &sleep_o;

  always_comb begin
    slp_cnt_d = slp_cnt_q;
    if (slp_cnt_clr_i)                    slp_cnt_d = '0;
    else if (core_sleep_o && !(&slp_cnt_q)) slp_cnt_d = slp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_ungated_i) begin
    if (!rst_n) slp_cnt_q <= '0;
    else        slp_cnt_q <= slp_cnt_d;
  end

  assign slp_cnt_o = slp_cnt_q;

endmodule

// File: tb/tb_cv32e40p_pm_unit.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_pm_unit
//   Directed bench for cv32e40p_pm_unit with three domains, IDLE_HYST=4,
//   WAKE_LAT=2 and a 4-bit sleep counter. Each step pushes the expected
//   outputs to a scoreboard, advances the clock, and then pops and compares
//   them against the DUT.
// -----------------------------------------------------------------------------

module tb_cv32e40p_pm_unit;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan;
  logic          fe_i;
  logic          fe_o;
  logic [ND-1:0] busy, sreq, wake;
  logic [ND-1:0] clk_en, clk_gated, rdy, slp;
  logic          core_sleep;
  logic          clr;
  logic [3:0]    cnt;

  cv32e40p_pm_unit #(
    .NUM_DOM   (ND),
    .IDLE_HYST (4),
    .WAKE_LAT  (2),
    .SLP_CNT_W (4)
  ) dut (
    .clk_ungated_i  (clk),
    .rst_n          (rst_n),
    .scan_cg_en_i   (scan),
    .fetch_enable_i (fe_i),
    .fetch_enable_o (fe_o),
    .busy_i         (busy),
    .sleep_req_i    (sreq),
    .wake_i         (wake),
    .clk_en_o       (clk_en),
    .clk_gated_o    (clk_gated),
    .ready_o        (rdy),
    .sleep_o        (slp),
    .core_sleep_o   (core_sleep),
    .slp_cnt_clr_i  (clr),
    .slp_cnt_o      (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rdy;
    logic [2:0] slp;
    logic [2:0] en;
    logic       core;
    logic [3:0] cnt;
    logic       fe;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic cmp(input string tag, input string field,
                     input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] r, input logic [2:0] s,
                      input logic [2:0] e, input logic c, input logic [3:0] n,
                      input logic f);
    exp_t x;
    x.rdy = r; x.slp = s; x.en = e; x.core = c; x.cnt = n; x.fe = f;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  x;
    string t;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "ready",      {1'b0, rdy},        {1'b0, x.rdy});
    cmp(t, "sleep",      {1'b0, slp},        {1'b0, x.slp});
    cmp(t, "clk_en",     {1'b0, clk_en},     {1'b0, x.en});
    cmp(t, "core_sleep", {3'b0, core_sleep}, {3'b0, x.core});
    cmp(t, "slp_cnt",    cnt,                x.cnt);
    cmp(t, "fetch_en",   {3'b0, fe_o},       {3'b0, x.fe});
  endtask

  // Expectation after the next rising edge.
  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] s,
                      input logic [2:0] e, input logic c, input logic [3:0] n,
                      input logic f);
    push(tag, r, s, e, c, n, f);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Expectation in the current cycle (combinational response to inputs).
  task automatic now(input string tag, input logic [2:0] r, input logic [2:0] s,
                     input logic [2:0] e, input logic c, input logic [3:0] n,
                     input logic f);
    push(tag, r, s, e, c, n, f);
    #1;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    rst_n = 1'b0; scan = 1'b0; fe_i = 1'b0; clr = 1'b0;
    busy = '0; sreq = '0; wake = '0;

    // Power-on reset, then OFF until the captured fetch enable is seen.
    step("por_a", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    step("por_b", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step("off_hold", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    fe_i = 1'b1;
    step("fe_capture", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b1);
    fe_i = 1'b0;
    step("fe_run", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);

    // Hysteresis: domain 0 gates on the 5th edge after its request.
    sreq = 3'b001;
    for (int i = 1; i <= 4; i++)
      step("t2_idle", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    step("t2_gate", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);

    // Domain 1: a busy pulse during the countdown sends it back to RUN.
    sreq = 3'b011;
    for (int i = 0; i < 3; i++)
      step("t2b_idle", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    busy = 3'b010;
    step("t2b_busy", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    busy = 3'b000;
    step("t2b_nogate", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    sreq = 3'b001;
    step("t2b_run", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);

    // Race on domain 2: wake together with sleep_req, first in RUN, then in IDLE.
    sreq = 3'b101; wake = 3'b100;
    for (int i = 0; i < 6; i++)
      step("t4_run", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    wake = 3'b000;
    step("t4_to_idle", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    wake = 3'b100;
    for (int i = 0; i < 5; i++)
      step("t4_idle", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    wake = 3'b000; sreq = 3'b001;
    step("t4_end", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);

    // Wake of domain 0: enable in the same cycle, ready after 3 edges.
    wake = 3'b001;
    now("t3_en", 3'b110, 3'b001, 3'b111, 1'b0, 4'd0, 1'b1);
    step("t3_wk1", 3'b110, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    wake = 3'b000; sreq = 3'b000;
    step("t3_wk2", 3'b110, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    step("t3_ready", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);

    // Staggered sleep of all three domains.
    sreq = 3'b001;
    step("t5_e1", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    sreq = 3'b011;
    step("t5_e2", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    sreq = 3'b111;
    step("t5_e3", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    step("t5_e4", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);
    step("t5_d0", 3'b110, 3'b001, 3'b110, 1'b0, 4'd0, 1'b1);
    step("t5_d1", 3'b100, 3'b011, 3'b100, 1'b0, 4'd0, 1'b1);
    step("t5_all", 3'b000, 3'b111, 3'b000, 1'b1, 4'd0, 1'b1);

    ec = 4'd0;
    for (int i = 0; i < 5; i++) begin
      ec = ec + 4'd1;
      step("t5_count", 3'b000, 3'b111, 3'b000, 1'b1, ec, 1'b1);
    end
    clr = 1'b1;
    step("t5_clr", 3'b000, 3'b111, 3'b000, 1'b1, 4'd0, 1'b1);
    clr = 1'b0;
    ec = 4'd0;
    for (int i = 0; i < 18; i++) begin
      ec = (ec == 4'd15) ? 4'd15 : ec + 4'd1;
      step("t5_sat", 3'b000, 3'b111, 3'b000, 1'b1, ec, 1'b1);
    end

    // Scan enable forces the gates open without moving the FSMs.
    scan = 1'b1;
    now("t6_scan", 3'b000, 3'b111, 3'b111, 1'b1, 4'd15, 1'b1);
    step("t6_hold", 3'b000, 3'b111, 3'b111, 1'b1, 4'd15, 1'b1);
    scan = 1'b0;
    step("t6_off", 3'b000, 3'b111, 3'b000, 1'b1, 4'd15, 1'b1);

    // Reset while every domain is asleep, then restart.
    rst_n = 1'b0;
    step("t1_rst_a", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    step("t1_rst_b", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1; fe_i = 1'b1;
    step("t1_fe", 3'b000, 3'b000, 3'b000, 1'b0, 4'd0, 1'b1);
    fe_i = 1'b0;
    step("t1_run", 3'b111, 3'b000, 3'b111, 1'b0, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
